// File: rtl/packet_buffer.sv
// packet_buffer: collects a length-prefixed packet from the UART deserializer,
// then drains the stored payload to the BPSK transmitter via valid/ready.
module packet_buffer #(
    parameter int MAX_LEN = 64,
    parameter int TIMEOUT = 110
) (
    input  logic       clk_baud,
    input  logic       reset_n,
    input  logic [7:0] uart_word,
    input  logic       uart_ready,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    output logic       tx_last,
    input  logic       tx_ready,
    output logic [7:0] pkt_len,
    output logic       busy,
    output logic       err_len,
    output logic       err_timeout,
    output logic       drop
);

    // Index width into mem; pointers carry one extra bit so they can hold MAX_LEN.
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int PW = $clog2(MAX_LEN) + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [7:0]    MAX_B   = 8'(MAX_LEN);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN} state_t;

    state_t        state_q;
    logic [7:0]    mem_q [MAX_LEN];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] to_cnt_q;
    logic [7:0]    pkt_len_q;
    logic          rdy_q;
    logic          err_len_q, err_to_q, drop_q;

    logic accept;
    logic last_wr;
    logic last_rd;

    // Rising edge of the deserializer strobe marks one new byte.
    assign accept  = uart_ready & ~rdy_q;
    assign last_wr = (8'(wr_ptr_q) == (pkt_len_q - 8'd1));
    assign last_rd = (8'(rd_ptr_q) == (pkt_len_q - 8'd1));

    assign tx_byte     = mem_q[rd_ptr_q[AW-1:0]];
    assign tx_valid    = (state_q == S_DRAIN);
    assign tx_last     = (state_q == S_DRAIN) && last_rd;
    assign pkt_len     = pkt_len_q;
    assign busy        = (state_q != S_IDLE);
    assign err_len     = err_len_q;
    assign err_timeout = err_to_q;
    assign drop        = drop_q;

    // Payload storage; contents are meaningless outside a packet, so no reset.
    always_ff @(posedge clk_baud) begin
        if (state_q == S_FILL && accept)
            mem_q[wr_ptr_q[AW-1:0]] <= uart_word;
    end

    // Packet FSM: header check, fill with stall timeout, drain with handshake.
    always_ff @(posedge clk_baud) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            to_cnt_q  <= '0;
            pkt_len_q <= '0;
            rdy_q     <= 1'b1;
            err_len_q <= 1'b0;
            err_to_q  <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            rdy_q     <= uart_ready;
            err_len_q <= 1'b0;
            err_to_q  <= 1'b0;
            drop_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (uart_word != 8'd0 && uart_word <= MAX_B) begin
                            pkt_len_q <= uart_word;
                            wr_ptr_q  <= '0;
                            to_cnt_q  <= '0;
                            state_q   <= S_FILL;
                        end else begin
                            err_len_q <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        wr_ptr_q <= wr_ptr_q + PW'(1);
                        to_cnt_q <= '0;
                        if (last_wr) begin
                            rd_ptr_q <= '0;
                            state_q  <= S_DRAIN;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        // Stalled packet: discard what was stored.
                        err_to_q <= 1'b1;
                        state_q  <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (accept)
                        drop_q <= 1'b1;
                    if (tx_ready) begin
                        rd_ptr_q <= rd_ptr_q + PW'(1);
                        if (last_rd)
                            state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/packet_buffer.md
# packet_buffer

Collects bytes from the UART deserializer into a length-prefixed packet, then drains the stored payload to the BPSK transmitter through a valid/ready handshake. It sits directly downstream of the UART deserializer, consuming its `uart_word`/`ready` pair, and directly upstream of the symbol/modulator path. Malformed headers and packets that stall mid-fill are rejected. Bytes arriving while a packet is draining are dropped and flagged.

## Interface
- `MAX_LEN`, default 64: largest accepted payload length in bytes (1..255).
- `TIMEOUT`, default 110: number of consecutive `clk_baud` cycles without an accepted byte, while in FILL, that aborts the packet. Must be at least 12.

- `clk_baud`  input  1: single clock, baud-synchronous, same clock as the deserializer.
- `reset_n`  input  1: synchronous, active-low reset.
- `uart_word`  input  8: byte from the deserializer.
- `uart_ready`  input  1: deserializer byte strobe; the byte is valid while high.
- `tx_byte`  output  8: current payload byte, equal to `mem[rd_ptr]` (combinational read).
- `tx_valid`  output  1: `tx_byte` is valid.
- `tx_last`  output  1: `tx_byte` is the final payload byte.
- `tx_ready`  input  1: downstream accepts `tx_byte` in this cycle.
- `pkt_len`  output  8: length of the packet being filled or drained; stable throughout DRAIN.
- `busy`  output  1: state is not IDLE.
- `err_len`  output  1: one-cycle pulse when a header is rejected.
- `err_timeout`  output  1: one-cycle pulse when a FILL times out.
- `drop`  output  1: one-cycle pulse when a byte is discarded during DRAIN.

## Operation
Byte acceptance
- An *accept event* occurs in a cycle where `uart_ready`=1 and the registered previous value of `uart_ready` (`rdy_q`) is 0.
- `rdy_q` resets to 1, so a strobe already high at reset release is not taken as an accept.
- Exactly one accept occurs per deserializer byte.

Storage
- `mem`: MAX_LEN x 8 bits.
- `wr_ptr` and `rd_ptr`: $clog2(MAX_LEN)+1 bits each.
- `to_cnt`: $clog2(TIMEOUT+1) bits.

States
- IDLE
  - Accept with `uart_word` in 1..MAX_LEN: `pkt_len` <= `uart_word`, `wr_ptr` <= 0, `to_cnt` <= 0, go to FILL.
  - Accept with `uart_word`=0 or greater than MAX_LEN: `err_len` pulses, stay in IDLE, `pkt_len` unchanged.
- FILL
  - Accept: `mem[wr_ptr]` <= `uart_word`, `wr_ptr`++, `to_cnt` <= 0.
  - If `wr_ptr` = `pkt_len`-1 at the accept, go to DRAIN with `rd_ptr` <= 0.
  - No accept: `to_cnt`++.
  - When `to_cnt` reaches TIMEOUT-1 with no accept in that cycle: `err_timeout` pulses, go to IDLE, stored bytes are discarded.
- DRAIN
  - `tx_valid`=1.
  - `tx_last` = (`rd_ptr` = `pkt_len`-1).
  - A transfer occurs when `tx_valid` and `tx_ready` are both 1; each transfer does `rd_ptr`++.
  - A transfer with `tx_last`=1 returns the block to IDLE.
  - Every accept in DRAIN is discarded and pulses `drop`, including an accept in the same cycle as the final transfer.
- `tx_valid` and `tx_last` are 0 outside DRAIN.
- `tx_byte` is don't-care while `tx_valid`=0.

## Timing
- Reset (`reset_n`=0 at a `clk_baud` edge):
  - State is IDLE.
  - All outputs are 0: `tx_valid`, `tx_last`, `busy`, `err_len`, `err_timeout`, `drop`, `pkt_len`=0.
  - Pointers and `to_cnt` are 0; `rdy_q`=1.
  - Reset mid-FILL or mid-DRAIN abandons the packet with no error pulse.
- Latency: `tx_valid` rises in the cycle after the accept of the last payload byte.
- `busy` rises in the cycle after the header accept and falls in the cycle after the final transfer.
- Error and drop pulses are registered: high for exactly the one cycle after the causing event.
- Once `tx_valid` is high, it stays high until the final transfer.
- `tx_byte` and `tx_last` change only after a transfer.
- `tx_ready` may be held high continuously, giving one byte per cycle, or toggled arbitrarily.
- A packet with `pkt_len`=1 enters DRAIN with `tx_last`=1 on the first cycle.
- With MAX_LEN=64, a header of 64 is accepted and a header of 65 is rejected.

## Test plan
- Header 3, then 0xA5, 0x5A, 0xFF spaced 11 cycles apart; `tx_ready`=1 -> `tx_byte` sequence A5, 5A, FF on consecutive cycles, `tx_last` only on FF, `pkt_len`=3, `busy` low afterwards.
- Header 0, then header 65 (MAX_LEN=64) -> two `err_len` pulses, `busy` stays 0. A following header 1 plus 0x42 -> a single-byte packet with `tx_last`=1.
- Header 4, two payload bytes, then silence -> `err_timeout` exactly TIMEOUT cycles after the last accept, return to IDLE. The next header 2 plus bytes 0x11, 0x22 -> drains 11, 22 only.
- Full packet of 2 with `tx_ready` held 0 for 30 cycles while 2 bytes arrive -> `tx_byte` holds the first byte, two `drop` pulses. Raising `tx_ready` then delivers both bytes, then IDLE.
- `uart_ready` held high for 3 cycles -> exactly one accept. `uart_ready` high at reset release -> no accept.
- Assert `reset_n`=0 for one cycle mid-DRAIN -> next cycle all outputs 0 and state IDLE. A new packet then works normally.
